// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared defaults and 100 MHz divisor constants for clk_en_gen
package clk_en_pkg;
  localparam int SYS_CLK_HZ = 100_000_000;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W = 27;
  localparam int DIV_FAST = SYS_CLK_HZ / 400;
  localparam int DIV_BLINK = SYS_CLK_HZ / 4;
  localparam int DIV_2HZ = SYS_CLK_HZ / 2;
  localparam int DIV_1HZ = SYS_CLK_HZ;
  localparam logic [DEF_NUM_CH*DEF_CNT_W-1:0] DEF_DIV_INIT = {
    DEF_CNT_W'(DIV_1HZ), DEF_CNT_W'(DIV_2HZ), DEF_CNT_W'(DIV_BLINK), DEF_CNT_W'(DIV_FAST)
  };
endpackage

// File: rtl/clk_en_chan.sv
// clk_en_chan: one divider channel with shadowed divisor, tick strobe and optional square (CLK_EN_SQUARE_EN)
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_val,
  input  logic             sync,
  input  logic             pause,
  output logic             tick,
  output logic             square
);
  logic [CNT_W-1:0] cnt, cnt_nxt, div, div_nxt, shadow, shadow_nxt;
  logic pending, pending_nxt, tick_nxt, wrap, run, apply;
  always_comb begin
    shadow_nxt = wr_en ? wr_val : shadow;
    wrap = div != '0 && cnt == div - CNT_W'(1);
    run = !sync && !pause && div != '0;
    apply = (wr_en || pending) && (sync || div == '0 || (run && wrap));
    div_nxt = apply ? shadow_nxt : div;
    pending_nxt = (wr_en || pending) && !apply;
    tick_nxt = run && wrap;
    cnt_nxt = (sync || div == '0 || tick_nxt) ? '0 : run ? cnt + CNT_W'(1) : cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      div <= DIV_RST;
      shadow <= DIV_RST;
      pending <= 1'b0;
      tick <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      div <= div_nxt;
      shadow <= shadow_nxt;
      pending <= pending_nxt;
      tick <= tick_nxt;
    end
  end
`ifdef CLK_EN_SQUARE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) square <= 1'b0;
    else square <= !sync && (square ^ tick_nxt);
  end
`else
  assign square = 1'b0;
`endif
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: NUM_CH programmable clock-enable channels; square outputs only with CLK_EN_SQUARE_EN
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = DEF_DIV_INIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      div_wr_en,
  input  logic [$clog2(NUM_CH)-1:0] div_wr_ch,
  input  logic [CNT_W-1:0]          div_wr_val,
  input  logic                      sync,
  input  logic                      pause,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         square
);
  localparam int CH_W = $clog2(NUM_CH);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_chan #(
      .CNT_W(CNT_W),
      .DIV_RST(DIV_INIT[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .wr_en(div_wr_en && div_wr_ch == CH_W'(i)),
      .wr_val(div_wr_val),
      .sync(sync),
      .pause(pause),
      .tick(tick[i]),
      .square(square[i])
    );
  end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: table, directed and random checks of clk_en_gen against a countdown reference model
module tb_clk_en_gen;
  logic clk, rst, div_wr_en, sync, pause;
  logic [1:0] div_wr_ch;
  logic [7:0] div_wr_val;
  logic [3:0] tick, square;
  int nvec = 0, nmis = 0;
`ifdef CLK_EN_SQUARE_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif
  clk_en_gen #(.NUM_CH(4), .CNT_W(8), .DIV_INIT({8'd5, 8'd3, 8'd2, 8'd1})) dut (
    .clk(clk), .rst(rst), .div_wr_en(div_wr_en), .div_wr_ch(div_wr_ch),
    .div_wr_val(div_wr_val), .sync(sync), .pause(pause), .tick(tick), .square(square)
  );
  initial clk = 1'b1;
  always #10 clk = ~clk;
  int act[4], shd[4], pend[4], rem[4];
  int init[4] = '{1, 2, 3, 5};
  logic [3:0] mt, msq;
  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      act[c] = init[c];
      shd[c] = init[c];
      pend[c] = 0;
      rem[c] = init[c];
    end
    mt = '0;
    msq = '0;
  endtask
  task automatic model_edge(input logic s, p, we, input logic [1:0] ch, input logic [7:0] v);
    for (int c = 0; c < 4; c++) begin
      automatic bit w = we && ch == 2'(c);
      automatic bit ep = w || pend[c] != 0;
      shd[c] = w ? int'(v) : shd[c];
      mt[c] = 1'b0;
      if (s) begin
        if (ep) act[c] = shd[c];
        pend[c] = 0;
        rem[c] = act[c];
        msq[c] = 1'b0;
      end else if (act[c] == 0) begin
        if (ep) begin
          act[c] = shd[c];
          rem[c] = act[c];
        end
        pend[c] = 0;
      end else if (p) begin
        pend[c] = int'(ep);
      end else begin
        rem[c]--;
        if (rem[c] == 0) begin
          mt[c] = 1'b1;
          msq[c] = ~msq[c];
          if (ep) act[c] = shd[c];
          pend[c] = 0;
          rem[c] = act[c];
        end else pend[c] = int'(ep);
      end
    end
  endtask
  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask
  task automatic step(input logic s, p, we, input logic [1:0] ch, input logic [7:0] v);
    sync = s;
    pause = p;
    div_wr_en = we;
    div_wr_ch = ch;
    div_wr_val = v;
    @(posedge clk);
    model_edge(s, p, we, ch, v);
    @(negedge clk);
    check("model_tick", tick, mt);
    check("model_square", square, SQ_EN ? msq : 4'b0);
  endtask
  task automatic wait_tick(input int c, output int n);
    n = 0;
    do begin
      step(0, 0, 0, 0, 0);
      n++;
    end while (!tick[c] && n < 40);
  endtask
  typedef struct {
    logic s, p;
    logic [3:0] tick, sq;
  } vec_t;
  vec_t tbl[10];
  initial begin
    int n, cnt;
    tbl[0] = '{0, 0, 4'b0001, 4'b0001};
    tbl[1] = '{0, 0, 4'b0011, 4'b0010};
    tbl[2] = '{0, 0, 4'b0101, 4'b0111};
    tbl[3] = '{0, 0, 4'b0011, 4'b0100};
    tbl[4] = '{0, 0, 4'b1001, 4'b1101};
    tbl[5] = '{0, 0, 4'b0111, 4'b1010};
    tbl[6] = '{0, 0, 4'b0001, 4'b1011};
    tbl[7] = '{0, 0, 4'b0011, 4'b1000};
    tbl[8] = '{0, 0, 4'b0101, 4'b1101};
    tbl[9] = '{0, 0, 4'b1011, 4'b0110};
    rst = 1'b1;
    {sync, pause, div_wr_en, div_wr_ch, div_wr_val} = '0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check("rst_tick", tick, 4'b0);
      check("rst_square", square, 4'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s, tbl[i].p, 0, 0, 0);
      check("tbl_tick", tick, tbl[i].tick);
      check("tbl_square", square, SQ_EN ? tbl[i].sq : 4'b0);
    end
    wait_tick(2, n);
    step(0, 0, 1, 2, 8'd4);
    n = 1;
    while (!tick[2] && n < 40) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    check("wr_old_gap", 4'(n), 4'd3);
    wait_tick(2, n);
    check("wr_new_gap", 4'(n), 4'd4);
    step(0, 0, 1, 1, 8'd0);
    repeat (3) step(0, 0, 0, 0, 0);
    cnt = 0;
    repeat (8) begin
      step(0, 0, 0, 0, 0);
      cnt += int'(tick[1]);
    end
    check("div0_ticks", 4'(cnt), 4'd0);
    step(0, 0, 1, 1, 8'd6);
    wait_tick(1, n);
    check("div0_restart", 4'(n), 4'd6);
    wait_tick(3, n);
    repeat (2) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 0, 0);
      check("pause_tick", tick, 4'b0);
    end
    wait_tick(3, n);
    check("pause_resume", 4'(n), 4'd3);
    step(0, 0, 1, 1, 8'd2);
    step(1, 0, 1, 2, 8'd3);
    check("sync_square", square, 4'b0);
    check("sync_tick", tick, 4'b0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 0, 0);
      check("sync_phase", {tick[3:1], 1'b1},
            {k % 5 == 0, k % 3 == 0, k % 2 == 0, 1'b1});
    end
    wait_tick(3, n);
    step(0, 0, 1, 3, 8'd7);
    repeat (2) step(0, 0, 0, 0, 0);
    #3 rst = 1'b1;
    #2;
    check("async_tick", tick, 4'b0);
    check("async_square", square, 4'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    wait_tick(3, n);
    check("rst_div3_first", 4'(n), 4'd5);
    wait_tick(3, n);
    check("rst_div3_period", 4'(n), 4'd5);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(31) == 0, $urandom_range(5) == 0, $urandom_range(7) == 0,
           2'($urandom_range(3)), 8'($urandom_range(7)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
